// File: rtl/issue_select.sv
// Issue select stage: picks up to two ready entries from the issue queue, pops them and
// registers them into two issue slots. Also owns the physical-register ready scoreboard.
module issue_select #(
  parameter int ENTRY_W   = 32,
  parameter int TAG_W     = 6,
  parameter int NUM_PREGS = 64,
  parameter int KEY_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] data0,
  input  logic [ENTRY_W-1:0] data1,
  input  logic [ENTRY_W-1:0] data2,
  input  logic [ENTRY_W-1:0] data3,
  input  logic [ENTRY_W-1:0] data4,
  input  logic [ENTRY_W-1:0] data5,
  input  logic [ENTRY_W-1:0] data6,
  input  logic [ENTRY_W-1:0] data7,
  output logic               pop0,
  output logic [KEY_W-1:0]   pop_key0,
  output logic               pop1,
  output logic [KEY_W-1:0]   pop_key1,
  input  logic               alloc0,
  input  logic               alloc1,
  input  logic [TAG_W-1:0]   alloc_tag0,
  input  logic [TAG_W-1:0]   alloc_tag1,
  input  logic               wb0,
  input  logic               wb1,
  input  logic [TAG_W-1:0]   wb_tag0,
  input  logic [TAG_W-1:0]   wb_tag1,
  output logic               iss0_valid,
  output logic               iss1_valid,
  output logic [ENTRY_W-1:0] iss0_data,
  output logic [ENTRY_W-1:0] iss1_data,
  input  logic               iss0_ready,
  input  logic               iss1_ready
);

  localparam int NUM_ENTRIES = 8;

  logic [ENTRY_W-1:0]   entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] eligible;
  logic [NUM_PREGS-1:0] sb;
  logic [NUM_PREGS-1:0] sb_next;
  logic                 slot0_free;
  logic                 slot1_free;
  logic                 first_found;
  logic                 second_found;
  logic [KEY_W-1:0]     first_key;
  logic [KEY_W-1:0]     second_key;

  assign entries[0] = data0;
  assign entries[1] = data1;
  assign entries[2] = data2;
  assign entries[3] = data3;
  assign entries[4] = data4;
  assign entries[5] = data5;
  assign entries[6] = data6;
  assign entries[7] = data7;

  // A source is ready from the scoreboard or by same-cycle writeback bypass.
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_elig
    logic [TAG_W-1:0] src1;
    logic [TAG_W-1:0] src2;
    logic             src1_rdy;
    logic             src2_rdy;
    assign src1     = entries[i][ENTRY_W-2 -: TAG_W];
    assign src2     = entries[i][ENTRY_W-2-TAG_W -: TAG_W];
    assign src1_rdy = sb[src1] | (wb0 && wb_tag0 == src1) | (wb1 && wb_tag1 == src1);
    assign src2_rdy = sb[src2] | (wb0 && wb_tag0 == src2) | (wb1 && wb_tag1 == src2);
    assign eligible[i] = entries[i][ENTRY_W-1] & src1_rdy & src2_rdy;
  end

  assign slot0_free = !iss0_valid || iss0_ready;
  assign slot1_free = !iss1_valid || iss1_ready;

  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_key    = '0;
    second_key   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (eligible[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_key   = KEY_W'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_key   = KEY_W'(i);
        end
      end
    end
  end

  // The oldest pick takes the lowest free slot; a second pick needs both slots free.
  always_comb begin
    pop0     = 1'b0;
    pop1     = 1'b0;
    pop_key0 = '0;
    pop_key1 = '0;
    if (!flush && !reset) begin
      if (slot0_free) begin
        pop0     = first_found;
        pop_key0 = first_key;
        if (slot1_free) begin
          pop1     = second_found;
          pop_key1 = second_key;
        end
      end else if (slot1_free) begin
        pop1     = first_found;
        pop_key1 = first_key;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
      iss0_data  <= '0;
      iss1_data  <= '0;
    end else if (flush) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
    end else begin
      if (slot0_free) begin
        iss0_valid <= pop0;
        if (pop0) iss0_data <= entries[pop_key0];
      end
      if (slot1_free) begin
        iss1_valid <= pop1;
        if (pop1) iss1_data <= entries[pop_key1];
      end
    end
  end

  // Allocation is applied after writeback so a same-tag collision leaves the tag busy.
  always_comb begin
    sb_next = sb;
    if (wb0)    sb_next[wb_tag0]    = 1'b1;
    if (wb1)    sb_next[wb_tag1]    = 1'b1;
    if (alloc0) sb_next[alloc_tag0] = 1'b0;
    if (alloc1) sb_next[alloc_tag1] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sb <= '1;
    else if (flush) sb <= '1;
    else            sb <= sb_next;
  end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: stimulus pushes expected issues into per-slot queues,
// a negedge monitor pops and compares them on every valid/ready transfer.
`timescale 1ns/1ps
module tb_issue_select;

  localparam int ENTRY_W = 32;
  localparam int TAG_W   = 6;
  localparam int KEY_W   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic [ENTRY_W-1:0] ent [8];
  logic               pop0, pop1;
  logic [KEY_W-1:0]   pop_key0, pop_key1;
  logic               alloc0, alloc1, wb0, wb1;
  logic [TAG_W-1:0]   alloc_tag0, alloc_tag1, wb_tag0, wb_tag1;
  logic               iss0_valid, iss1_valid;
  logic [ENTRY_W-1:0] iss0_data, iss1_data;
  logic               iss0_ready, iss1_ready;

  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [ENTRY_W-1:0] q0 [$];
  logic [ENTRY_W-1:0] q1 [$];

  always #10 clk = ~clk;

  issue_select dut (
    .clk(clk), .reset(reset), .flush(flush),
    .data0(ent[0]), .data1(ent[1]), .data2(ent[2]), .data3(ent[3]),
    .data4(ent[4]), .data5(ent[5]), .data6(ent[6]), .data7(ent[7]),
    .pop0(pop0), .pop_key0(pop_key0), .pop1(pop1), .pop_key1(pop_key1),
    .alloc0(alloc0), .alloc1(alloc1), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .wb0(wb0), .wb1(wb1), .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
    .iss0_data(iss0_data), .iss1_data(iss1_data),
    .iss0_ready(iss0_ready), .iss1_ready(iss1_ready)
  );

  function automatic logic [ENTRY_W-1:0] mk(input logic [5:0] s1, input logic [5:0] s2,
                                            input logic [5:0] d, input logic [12:0] p);
    return {1'b1, s1, s2, d, p};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkPops(input logic p0, input logic [KEY_W-1:0] k0,
                           input logic p1, input logic [KEY_W-1:0] k1);
    checkOutput("pop0", 32'(pop0), 32'(p0));
    if (p0) checkOutput("pop_key0", 32'(pop_key0), 32'(k0));
    checkOutput("pop1", 32'(pop1), 32'(p1));
    if (p1) checkOutput("pop_key1", 32'(pop_key1), 32'(k1));
  endtask

  // Advance to the drive window two time units after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic clearEntries();
    for (int i = 0; i < 8; i++) ent[i] = '0;
  endtask

  task automatic expectIssue(input int slot, input logic [ENTRY_W-1:0] d);
    if (slot == 0) q0.push_back(d);
    else           q1.push_back(d);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (iss0_valid && iss0_ready) begin
        if (q0.size() == 0) checkOutput("slot0 unexpected issue", iss0_data, 32'hx);
        else                checkOutput("slot0 issue data", iss0_data, q0.pop_front());
      end
      if (iss1_valid && iss1_ready) begin
        if (q1.size() == 0) checkOutput("slot1 unexpected issue", iss1_data, 32'hx);
        else                checkOutput("slot1 issue data", iss1_data, q1.pop_front());
      end
    end
  end

  logic [ENTRY_W-1:0] e0, e1, e2, e3, e4, e5;
  int a, b;

  initial begin
    reset = 1'b1; flush = 1'b0;
    alloc0 = 0; alloc1 = 0; wb0 = 0; wb1 = 0;
    alloc_tag0 = '0; alloc_tag1 = '0; wb_tag0 = '0; wb_tag1 = '0;
    iss0_ready = 1'b1; iss1_ready = 1'b1;
    clearEntries();
    e0 = mk(6'd1, 6'd2, 6'd3, 13'h0011);
    ent[0] = e0;
    #3;
    checkPops(0, 0, 0, 0);
    checkOutput("reset iss0_valid", 32'(iss0_valid), 0);
    checkOutput("reset iss1_valid", 32'(iss1_valid), 0);
    checkOutput("reset iss0_data", iss0_data, 0);
    #22 reset = 1'b0;
    #1;
    checkPops(1, 0, 0, 0);
    expectIssue(0, e0);

    // Allocate tag 5 with no eligible entries present.
    applyStimulus();
    clearEntries();
    alloc0 = 1; alloc_tag0 = 6'd5;
    #1;
    checkOutput("latency iss0_valid", 32'(iss0_valid), 1);
    checkOutput("latency iss0_data", iss0_data, e0);
    checkPops(0, 0, 0, 0);

    // Entry 1 waits on tag 5, entry 4 is ready.
    applyStimulus();
    alloc0 = 0;
    e1 = mk(6'd5, 6'd2, 6'd7, 13'h0022);
    e2 = mk(6'd1, 6'd2, 6'd9, 13'h0044);
    ent[1] = e1; ent[4] = e2;
    #1;
    checkOutput("idle slot cleared", 32'(iss0_valid), 0);
    checkPops(1, 4, 0, 0);
    expectIssue(0, e2);

    // Writeback of tag 5 bypasses into entry 1.
    applyStimulus();
    ent[4] = '0;
    wb0 = 1; wb_tag0 = 6'd5;
    #1;
    checkPops(1, 1, 0, 0);
    expectIssue(0, e1);

    // Slot 0 stalls, slot 1 takes the oldest ready entry.
    applyStimulus();
    wb0 = 0; ent[1] = '0;
    iss0_ready = 0;
    e3 = mk(6'd3, 6'd4, 6'd10, 13'h0101);
    e4 = mk(6'd4, 6'd3, 6'd11, 13'h0202);
    e5 = mk(6'd2, 6'd2, 6'd12, 13'h0303);
    ent[2] = e3; ent[3] = e4; ent[6] = e5;
    #1;
    checkPops(0, 0, 1, 2);
    expectIssue(1, e3);

    applyStimulus();
    ent[2] = '0;
    #1;
    checkOutput("stall iss0_valid", 32'(iss0_valid), 1);
    checkOutput("stall iss0_data", iss0_data, e1);
    checkPops(0, 0, 1, 3);
    expectIssue(1, e4);

    // Both slots free: entries 6 and 7 issue together.
    applyStimulus();
    iss0_ready = 1; ent[3] = '0;
    e0 = mk(6'd1, 6'd1, 6'd13, 13'h0404);
    ent[7] = e0;
    #1;
    checkPops(1, 6, 1, 7);
    expectIssue(0, e5);
    expectIssue(1, e0);

    // Sustained dual issue with the queue refilling every cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      clearEntries();
      a = i % 4;
      b = a + 1 + (i % 3);
      e1 = mk(6'd1, 6'd2, 6'(20 + i), 13'(16'h1000 + i));
      e2 = mk(6'd2, 6'd1, 6'(30 + i), 13'(16'h0800 + i));
      ent[a] = e1; ent[b] = e2;
      if (i == 7) begin
        alloc0 = 1; alloc_tag0 = 6'd5;
        wb1 = 1; wb_tag1 = 6'd5;
      end
      #1;
      checkPops(1, KEY_W'(a), 1, KEY_W'(b));
      checkOutput("distinct keys", 32'(pop_key0 != pop_key1), 1);
      expectIssue(0, e1);
      expectIssue(1, e2);
    end

    // Tag 5 stays busy because allocation beat the same-cycle writeback.
    applyStimulus();
    alloc0 = 0; wb1 = 0;
    clearEntries();
    e1 = mk(6'd5, 6'd1, 6'd40, 13'h0505);
    e2 = mk(6'd1, 6'd2, 6'd41, 13'h0606);
    e3 = mk(6'd2, 6'd1, 6'd42, 13'h0707);
    ent[0] = e1; ent[2] = e2; ent[3] = e3;
    #1;
    checkPops(1, 2, 1, 3);

    // Flush with both slots valid and stalled; the held entries are discarded.
    applyStimulus();
    iss0_ready = 0; iss1_ready = 0;
    ent[2] = '0; ent[3] = '0;
    ent[1] = e2;
    flush = 1;
    #1;
    checkPops(0, 0, 0, 0);
    checkOutput("preflush iss0_valid", 32'(iss0_valid), 1);
    checkOutput("preflush iss1_valid", 32'(iss1_valid), 1);
    q0.delete(); q1.delete();

    applyStimulus();
    flush = 0;
    iss0_ready = 1; iss1_ready = 1;
    ent[1] = '0;
    #1;
    checkOutput("flush iss0_valid", 32'(iss0_valid), 0);
    checkOutput("flush iss1_valid", 32'(iss1_valid), 0);
    checkPops(1, 0, 0, 0);
    expectIssue(0, e1);

    applyStimulus();
    clearEntries();
    e4 = mk(6'd3, 6'd3, 6'd43, 13'h0808);
    e5 = mk(6'd4, 6'd4, 6'd44, 13'h0909);
    ent[1] = e4; ent[3] = e5;
    #1;
    checkPops(1, 1, 1, 3);
    expectIssue(0, e4);
    expectIssue(1, e5);

    // Asynchronous reset between edges while both slots are valid.
    applyStimulus();
    clearEntries();
    iss0_ready = 0; iss1_ready = 0;
    #1;
    checkOutput("prereset iss0_valid", 32'(iss0_valid), 1);
    checkOutput("prereset iss1_valid", 32'(iss1_valid), 1);
    q0.delete(); q1.delete();
    #2 reset = 1;
    #1;
    checkOutput("async iss0_valid", 32'(iss0_valid), 0);
    checkOutput("async iss1_valid", 32'(iss1_valid), 0);
    checkOutput("async iss1_data", iss1_data, 0);
    e0 = mk(6'd1, 6'd1, 6'd45, 13'h0a0a);
    e1 = mk(6'd2, 6'd2, 6'd46, 13'h0b0b);
    ent[0] = e0; ent[2] = e1;
    iss0_ready = 1; iss1_ready = 1;
    #1;
    checkPops(0, 0, 0, 0);
    #1 reset = 0;
    #1;
    checkPops(1, 0, 1, 2);
    expectIssue(0, e0);
    expectIssue(1, e1);

    applyStimulus();
    clearEntries();
    applyStimulus();
    #1;
    checkOutput("slot0 queue drained", 32'(q0.size()), 0);
    checkOutput("slot1 queue drained", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Scheduler stage directly downstream of issue_queue. Each cycle it examines the eight exported queue entries and picks up to two whose source operands are ready.
- For each pick it drives pop0/pop_key0 and pop1/pop_key1 back into the queue and registers the picked entries into two issue slots with valid/ready handshakes toward the execute pipes.
- Owns the physical-register ready scoreboard used for wakeup.

Parameters:
- ENTRY_W, `IQ_ENTRY_SIZE: issue-queue entry width.
- TAG_W, 6: physical register tag width.
- NUM_PREGS, 64: scoreboard depth, equal to 2**TAG_W.
- KEY_W, `NUM_IQ_ENTRIES_LOG2: entry index width, 3.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous pipeline flush.
- data0..data7  input  ENTRY_W each  queue entries; index 0 is oldest.
- pop0  output  1  pop request, port 0.
- pop_key0  output  KEY_W  index to pop, port 0.
- pop1  output  1  pop request, port 1.
- pop_key1  output  KEY_W  index to pop, port 1.
- alloc0, alloc1  input  1  dispatch allocating a destination tag.
- alloc_tag0, alloc_tag1  input  TAG_W  allocated destination tag.
- wb0, wb1  input  1  writeback valid.
- wb_tag0, wb_tag1  input  TAG_W  writeback tag.
- iss0_valid, iss1_valid  output  1  issue slot holds an instruction.
- iss0_data, iss1_data  output  ENTRY_W  issued entry.
- iss0_ready, iss1_ready  input  1  execute pipe accepts the slot contents.

Behaviour:
- Entry layout:
  - bit ENTRY_W-1 = valid.
  - bits [ENTRY_W-2 -: TAG_W] = src1 tag.
  - next TAG_W bits = src2 tag.
  - next TAG_W bits = dest tag.
  - remainder = payload; passed through untouched.
- Scoreboard: NUM_PREGS ready bits.
  - Reset: all 1.
  - alloc clears the bit for alloc_tag; wb sets the bit for wb_tag.
  - Same-cycle alloc and wb on the same tag: alloc wins (bit = 0).
  - Flush: all bits set to 1, alloc/wb ignored that cycle.
- Entry eligibility, combinational: valid, and each source is ready where ready = scoreboard bit OR matching wb0/wb1 tag this cycle (same-cycle bypass).
- Slot free: slot k is free when iss_k_valid == 0 or iss_k_ready == 1.
- Selection, combinational:
  - First pick = lowest eligible index; second pick = next-lowest eligible index above it.
  - First pick goes to the lowest-numbered free slot. The second pick goes only if the other slot is also free.
  - pop0 carries the pick routed to slot 0 and pop1 the pick routed to slot 1, regardless of age.
  - Keys refer to indices as presented this cycle; the queue applies both pops at the same edge.
  - pop0/pop1 are never asserted with equal keys.
- Issue registers, at the rising edge:
  - A free slot loads the entry popped into it (valid=1), or clears to valid=0 if no pick was routed to it.
  - A non-free slot holds its contents: stall, valid stays 1, data stable.
- Latency: an entry eligible at cycle N appears on iss_data at cycle N+1 (one-edge latency).
- Flush:
  - pop0/pop1 are forced to 0 the same cycle.
  - At the edge, iss0_valid and iss1_valid clear to 0 and the scoreboard is set to all ready.
- Reset, asynchronous, also mid-operation:
  - iss0_valid = iss1_valid = 0 and iss0_data = iss1_data = 0.
  - Scoreboard all 1.
  - pop0/pop1 read 0 while reset is high.
- Empty queue (all valid bits 0): no pops, and free slots clear.
- No eligible entries: same as empty.
- Pop outputs are purely combinational from the current entries, scoreboard, wb, flush and slot state.

Test Plan:
- After reset, data0 = valid entry (src 1, src 2, dest 3), all others invalid, both slots ready -> pop0=1, pop_key0=0, pop1=0; next edge iss0_valid=1, iss0_data=data0.
- alloc_tag0=5 at cycle 1; data1 has src1=5 and data4 is ready -> pop_key0=4 only. Then wb_tag0=5 at cycle 3 -> entry 1 popped that cycle via bypass and issued on the next edge.
- Entries 2, 3, 6 ready, iss0_valid=1 with iss0_ready=0, slot 1 free -> pop0=0, pop1=1, pop_key1=2; slot 0 data unchanged across the edge.
- Entries 6 and 7 ready, both slots free -> pop_key0=6, pop_key1=7, both slots load the next edge. Hold for 8 cycles with the queue refilling -> two issues per cycle, no duplicate keys.
- Flush asserted while both slots are valid and the scoreboard has tag 5 busy -> pop0=pop1=0 that cycle; next edge both iss_valid=0 and tag 5 ready.
- Assert reset asynchronously between edges while both slots are valid -> iss_valid drops immediately without a clock edge. After deassertion, selection resumes from index 0.
